// File: rtl/strip_frame_sequencer_pkg.sv
// Shared types and timing defaults for the LED strip frame sequencer.
// Defaults assume a 12 MHz system clock driving xx6812-style LEDs.
package strip_frame_sequencer_pkg;

  localparam int LED_WORD_W = 24;
  localparam int CLOCK_MHZ = 12;
  localparam int DEFAULT_LED_CYCLES = CLOCK_MHZ * 30;
  localparam int DEFAULT_LATCH_CYCLES = CLOCK_MHZ * 300;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SLOT,
    ST_LATCH
  } seqState_e;

  // Width of the shared slot/latch timer: must hold the larger of the two reload values.
  function automatic int timerWidth(input int ledCycles, input int latchCycles);
    int maxLoad;
    maxLoad = (ledCycles - 1 > latchCycles) ? ledCycles - 1 : latchCycles;
    return $clog2(maxLoad + 1);
  endfunction

endpackage

// File: rtl/strip_frame_sequencer_timer.sv
// Loadable down-counter; tc_o is high for one cycle when a loaded count reaches zero.
// A load in the same cycle as tc_o restarts the count, giving a jitter-free period.
module sequencer_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic             armed_q;

  assign tc_o = armed_q && (count_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      count_q <= loadValue_i;
      armed_q <= 1'b1;
    end else if (tc_o) begin
      armed_q <= 1'b0;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/strip_frame_sequencer.sv
// Per-frame LED strip sequencer: reads GRB words from LED RAM in address order and
// loads them into the serial encoder exactly one LED slot apart, then holds a latch gap.
module strip_frame_sequencer
  import strip_frame_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int LED_CYCLES   = DEFAULT_LED_CYCLES,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH:0]   led_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic [LED_WORD_W-1:0] mem_data,
  output logic [LED_WORD_W-1:0] encoder_data,
  output logic                  encoder_load,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int TIMER_W = timerWidth(LED_CYCLES, LATCH_CYCLES);
  localparam logic [TIMER_W-1:0] SLOT_RELOAD = TIMER_W'(LED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LATCH_RELOAD = TIMER_W'(LATCH_CYCLES);
  localparam logic [ADDR_WIDTH:0] MAX_LEDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  seqState_e             state_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic                  memRead_q;
  logic                  capture_q;
  logic [LED_WORD_W-1:0] encoderData_q;
  logic                  encoderLoad_q;
  logic                  busy_q;
  logic                  frameDone_q;
  logic                  overrun_q;
  logic [ADDR_WIDTH:0]   remaining_q;

  logic                  accept;
  logic                  slotTick;
  logic [ADDR_WIDTH:0]   acceptCount;
  logic                  timerLoad;
  logic [TIMER_W-1:0]    timerValue;
  logic                  timerTc;

  // The last slot tick starts the latch timer directly, so the latch gap absorbs the
  // two-cycle read-to-load pipeline of the final LED.
  always_comb begin
    accept      = (state_q == ST_IDLE) && frame_start && enable && (led_count != '0);
    slotTick    = (state_q == ST_SLOT) && timerTc;
    acceptCount = (led_count > MAX_LEDS) ? MAX_LEDS : led_count;
    timerLoad   = accept || slotTick;
    timerValue  = (slotTick && (remaining_q == '0)) ? LATCH_RELOAD : SLOT_RELOAD;
  end

  sequencer_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (timerLoad),
    .loadValue_i(timerValue),
    .tc_o       (timerTc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      memAddr_q     <= '0;
      memRead_q     <= 1'b0;
      capture_q     <= 1'b0;
      encoderData_q <= '0;
      encoderLoad_q <= 1'b0;
      busy_q        <= 1'b0;
      frameDone_q   <= 1'b0;
      overrun_q     <= 1'b0;
      remaining_q   <= '0;
    end else begin
      memRead_q     <= 1'b0;
      encoderLoad_q <= 1'b0;
      frameDone_q   <= 1'b0;
      overrun_q     <= frame_start && busy_q;
      capture_q     <= memRead_q;
      if (capture_q) begin
        encoderData_q <= mem_data;
        encoderLoad_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_FETCH;
            busy_q      <= 1'b1;
            memRead_q   <= 1'b1;
            memAddr_q   <= '0;
            remaining_q <= acceptCount - 1'b1;
          end
        end
        ST_FETCH: state_q <= ST_SLOT;
        ST_SLOT: begin
          if (timerTc) begin
            if (remaining_q != '0) begin
              state_q     <= ST_FETCH;
              memRead_q   <= 1'b1;
              memAddr_q   <= memAddr_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
            end else begin
              state_q <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (frameDone_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (timerTc) begin
            frameDone_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr     = memAddr_q;
  assign mem_read     = memRead_q;
  assign encoder_data = encoderData_q;
  assign encoder_load = encoderLoad_q;
  assign busy         = busy_q;
  assign frame_done   = frameDone_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_strip_frame_sequencer.sv
// Directed self-checking bench for strip_frame_sequencer, using short slot/latch
// timings (LC=12, LT=50) so a full 256-LED frame stays small.
module tb_strip_frame_sequencer;

  localparam int AW = 8;
  localparam int LC = 12;
  localparam int LT = 50;
  localparam int DONE3 = 3 + 3 * LC + LT - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW:0]   led_count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic [23:0]   mem_data = '0;
  logic [23:0]   encoder_data;
  logic          encoder_load;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  logic [23:0] ram [0:255];
  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;
  int scratch = 0;
  int readCyc[$];
  int readAddr[$];
  int loadCyc[$];
  int loadData[$];
  int doneCyc[$];
  int overCyc[$];
  int busyRise[$];
  logic busyPrev = 1'b0;

  strip_frame_sequencer #(
    .ADDR_WIDTH  (AW),
    .LED_CYCLES  (LC),
    .LATCH_CYCLES(LT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .frame_start (frame_start),
    .led_count   (led_count),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_data    (mem_data),
    .encoder_data(encoder_data),
    .encoder_load(encoder_load),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read LED RAM: data follows the read strobe by one cycle.
  always @(posedge clock) if (mem_read) mem_data <= ram[mem_addr];

  always @(negedge clock) begin
    if (mem_read) begin
      readCyc.push_back(cyc);
      readAddr.push_back(int'(mem_addr));
    end
    if (encoder_load) begin
      loadCyc.push_back(cyc);
      loadData.push_back(int'(encoder_data));
    end
    if (frame_done) doneCyc.push_back(cyc);
    if (overrun) overCyc.push_back(cyc);
    if (busy && !busyPrev) busyRise.push_back(cyc);
    busyPrev = busy;
  end

  function automatic logic [23:0] patWord(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A};
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed,
               expected, expected);
    end
  endtask

  task automatic clearLog();
    readCyc.delete();
    readAddr.delete();
    loadCyc.delete();
    loadData.delete();
    doneCyc.delete();
    overCyc.delete();
    busyRise.delete();
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulseStart(output int at);
    frame_start = 1'b1;
    at = cyc;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic en);
    led_count = (AW + 1)'(n);
    enable = en;
    pulseStart(t0);
  endtask

  task automatic checkFrame3(input string pfx);
    logic [23:0] words [3];
    words = '{24'h800080, 24'h00FF00, 24'h0000FF};
    checkOutput({pfx, " read count"}, readCyc.size(), 3);
    checkOutput({pfx, " load count"}, loadCyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s read%0d cyc", pfx, i), (i < readCyc.size()) ? readCyc[i] - t0 : -1,
                  1 + i * LC);
      checkOutput($sformatf("%s read%0d addr", pfx, i), (i < readAddr.size()) ? readAddr[i] : -1, i);
      checkOutput($sformatf("%s load%0d cyc", pfx, i), (i < loadCyc.size()) ? loadCyc[i] - t0 : -1,
                  3 + i * LC);
      checkOutput($sformatf("%s load%0d data", pfx, i), (i < loadData.size()) ? loadData[i] : -1,
                  int'(words[i]));
    end
    checkOutput({pfx, " done count"}, doneCyc.size(), 1);
    checkOutput({pfx, " done cyc"}, (doneCyc.size() > 0) ? doneCyc[0] - t0 : -1, DONE3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = patWord(i);
    ram[0] = 24'h800080;
    ram[1] = 24'h00FF00;
    ram[2] = 24'h0000FF;

    #12;
    checkOutput("reset mem_read", int'(mem_read), 0);
    checkOutput("reset mem_addr", int'(mem_addr), 0);
    checkOutput("reset enc_load", int'(encoder_load), 0);
    checkOutput("reset enc_data", int'(encoder_data), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    waitUntil(cyc + 2);

    // Basic three-LED frame.
    clearLog();
    applyStimulus(3, 1'b1);
    waitUntil(t0 + DONE3);
    checkOutput("f1 busy at done", int'(busy), 1);
    checkOutput("f1 done level", int'(frame_done), 1);
    waitUntil(t0 + DONE3 + 1);
    checkOutput("f1 busy after done", int'(busy), 0);
    checkOutput("f1 enc_data held", int'(encoder_data), 24'h0000FF);
    checkFrame3("f1");
    checkOutput("f1 overruns", overCyc.size(), 0);
    waitUntil(cyc + 5);

    // Requests while busy, including one in the frame_done cycle.
    clearLog();
    applyStimulus(3, 1'b1);
    waitUntil(t0 + 40);
    pulseStart(scratch);
    waitUntil(t0 + DONE3);
    pulseStart(scratch);
    waitUntil(t0 + 120);
    checkFrame3("f2");
    checkOutput("f2 overrun count", overCyc.size(), 2);
    checkOutput("f2 overrun0 cyc", (overCyc.size() > 0) ? overCyc[0] - t0 : -1, 41);
    checkOutput("f2 overrun1 cyc", (overCyc.size() > 1) ? overCyc[1] - t0 : -1, DONE3 + 1);
    checkOutput("f2 busy rises", busyRise.size(), 1);

    // Ignored requests: zero LEDs, then enable low.
    clearLog();
    applyStimulus(0, 1'b1);
    waitUntil(t0 + 30);
    applyStimulus(3, 1'b0);
    waitUntil(t0 + 30);
    checkOutput("ign reads", readCyc.size(), 0);
    checkOutput("ign loads", loadCyc.size(), 0);
    checkOutput("ign busy", busyRise.size(), 0);
    checkOutput("ign overruns", overCyc.size(), 0);
    enable = 1'b1;

    // Oversized count clamps to 256 LEDs with no address wrap.
    clearLog();
    applyStimulus(300, 1'b1);
    waitUntil(t0 + 3 + 256 * LC + LT + 10);
    checkOutput("big read count", readCyc.size(), 256);
    checkOutput("big load count", loadCyc.size(), 256);
    checkOutput("big first addr", (readAddr.size() > 0) ? readAddr[0] : -1, 0);
    checkOutput("big last addr", (readAddr.size() == 256) ? readAddr[255] : -1, 255);
    checkOutput("big last read cyc", (readCyc.size() == 256) ? readCyc[255] - t0 : -1, 1 + 255 * LC);
    checkOutput("big last load cyc", (loadCyc.size() == 256) ? loadCyc[255] - t0 : -1, 3 + 255 * LC);
    checkOutput("big load3 data", (loadData.size() > 3) ? loadData[3] : -1, int'(patWord(3)));
    checkOutput("big last data", (loadData.size() == 256) ? loadData[255] : -1, int'(patWord(255)));
    checkOutput("big done cyc", (doneCyc.size() > 0) ? doneCyc[0] - t0 : -1, 3 + 256 * LC + LT - 1);
    checkOutput("big busy end", int'(busy), 0);

    // Asynchronous reset mid-cycle in slot 1.
    clearLog();
    applyStimulus(3, 1'b1);
    waitUntil(t0 + 3 + LC);
    checkOutput("rst pre load", int'(encoder_load), 1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst enc_load", int'(encoder_load), 0);
    checkOutput("rst enc_data", int'(encoder_data), 0);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst mem_addr", int'(mem_addr), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    clearLog();
    waitUntil(cyc + 120);
    checkOutput("rst stray done", doneCyc.size(), 0);
    checkOutput("rst stray reads", readCyc.size(), 0);

    // Restart from address 0, then a back-to-back frame.
    clearLog();
    applyStimulus(3, 1'b1);
    waitUntil(t0 + DONE3 + 1);
    checkOutput("b2b busy low", int'(busy), 0);
    checkFrame3("restart");
    clearLog();
    applyStimulus(3, 1'b1);
    waitUntil(t0 + DONE3 + 5);
    checkFrame3("b2b");
    checkOutput("b2b overruns", overCyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/strip_frame_sequencer.md
Name: strip_frame_sequencer

Overview:
Sequences one LED strip per frame: on each frame tick, fetches LED colour words (GRB, 24 bit) from the LED memory in address order and hands them to encoder_xx6812 one LED slot apart. After the last LED it holds a latch gap (line low) before accepting the next frame. Sits between clock_generator (framerate), the LED RAM and encoder_xx6812; replaces the fixed-data, edge-detected encoder reset in top.

Parameters:
ADDR_WIDTH, 8, LED memory address width; max LEDs = 2**ADDR_WIDTH
LED_CYCLES, 360, clock cycles per LED slot (24 bits x 1.25 us at 12 MHz); must be >= 4
LATCH_CYCLES, 3600, clock cycles of latch gap after last slot (300 us at 12 MHz); must be >= 1

Ports:
clock  in  1  system clock (12 MHz), all logic on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  high: new frames may start
frame_start  in  1  single-cycle frame request (framerate edge, synchronised upstream)
led_count  in  ADDR_WIDTH+1  LEDs per frame, sampled at frame accept
mem_addr  out  ADDR_WIDTH  LED memory read address
mem_read  out  1  read strobe; mem_data valid in the following cycle
mem_data  in  24  LED memory read data
encoder_data  out  24  parallel word to encoder_xx6812
encoder_load  out  1  single-cycle strobe: encoder_data valid, start serialising (drives encoder reset)
busy  out  1  frame in progress (slots or latch)
frame_done  out  1  single-cycle pulse at end of latch gap
overrun  out  1  single-cycle pulse: frame_start while busy

Behaviour:
- Reset (reset low, async): all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately; no frame_done.
- All outputs registered.
- States: IDLE -> FETCH -> SLOT -> LATCH -> IDLE.
- IDLE: frame_start=1 and enable=1 and led_count!=0 accepted; count latched (values > 2**ADDR_WIDTH clamp to 2**ADDR_WIDTH); busy=1 from next cycle.
- Timing, frame_start in cycle 0: mem_read=1, mem_addr=0 in cycle 1; mem_data captured end of cycle 2; encoder_load=1 with encoder_data=word in cycle 3.
- LED i: mem_read cycle 1+i*LED_CYCLES, addr i; encoder_load cycle 3+i*LED_CYCLES. Loads exactly LED_CYCLES apart, never jitter.
- encoder_data holds last loaded word until next load or reset.
- After last load, slot completes at cycle 3+n*LED_CYCLES; LATCH counts LATCH_CYCLES; frame_done=1 in cycle 3+n*LED_CYCLES+LATCH_CYCLES-1; busy=0 from the following cycle, which may accept a new frame_start.
- No mem_read for addresses >= n; exactly n reads and n loads per frame.
- frame_start while busy: ignored, overrun=1 next cycle, frame unaffected. Not flagged when enable=0 in IDLE.
- led_count=0 or enable=0 in IDLE: frame_start ignored silently.
- enable dropping mid-frame: current frame completes normally.
- frame_start coinciding with frame_done cycle: still busy, counts as overrun.
- led_count changes mid-frame: no effect.

Decomposition:
- Shared package/header: state encodings, LED word width (24), default timing constants derived from 12 MHz.
- One sub-module natural: sequencer_timer (loadable down-counter with terminal-count pulse), used for both slot and latch timing.

Test Plan:
- Reset, led_count=3, LED_CYCLES=360, LATCH_CYCLES=3600, RAM {0x800080,0x00FF00,0x0000FF}, frame_start cycle 0 -> loads cycles 3,363,723 with those words; reads addr 0,1,2 at 1,361,721; frame_done cycle 4682; busy low cycle 4683.
- frame_start at cycles 0 and 500 (n=3) -> overrun pulse cycle 501; load times unchanged; single frame_done.
- led_count=0, and separately enable=0, with frame_start -> no mem_read, load, busy or overrun.
- led_count=300, ADDR_WIDTH=8 -> exactly 256 loads, last address 255, no wrap to 0.
- reset low asynchronously mid-cycle during slot 1 -> all outputs 0 immediately; after release, frame_start restarts from addr 0, no stray frame_done.
- Back-to-back: frame_start the cycle after frame_done -> accepted, first load 3 cycles later, no overrun.
